// File: rtl/judge.sv
// judge: four-client round-robin arbiter with registered one-hot grants.
// Optional grant locking is enabled by defining JUDGE_LOCK_EN.
module judge #(
    parameter int RESET_LAST = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic req3,
    input  logic req2,
    input  logic req1,
    input  logic req0,
    output logic gnt3,
    output logic gnt2,
    output logic gnt1,
    output logic gnt0
);

    localparam logic [1:0] LAST_INIT = RESET_LAST[1:0];

    logic [3:0] req;
    logic [3:0] gnt_q;
    logic [3:0] gnt_d;
    logic [1:0] last_q;
    logic [1:0] last_d;
    logic       hold;
    logic       found;
    logic [1:0] idx;

    assign req = {req3, req2, req1, req0};

`ifdef JUDGE_LOCK_EN
    // Current holder keeps the grant while its request stays high.
    assign hold = |(gnt_q & req);
`else
    assign hold = 1'b0;
`endif

    // Circular scan starting after the last grantee, wrapping onto it.
    always_comb begin
        gnt_d  = 4'b0000;
        last_d = last_q;
        found  = 1'b0;
        idx    = 2'd0;
        if (hold) begin
            gnt_d = gnt_q;
        end else begin
            for (int i = 1; i < 5; i++) begin
                idx = last_q + i[1:0];
                if (!found && req[idx]) begin
                    found      = 1'b1;
                    gnt_d[idx] = 1'b1;
                    last_d     = idx;
                end
            end
        end
    end

    // Grant and pointer registers; reset clears grants immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gnt_q  <= 4'b0000;
            last_q <= LAST_INIT;
        end else begin
            gnt_q  <= gnt_d;
            last_q <= last_d;
        end
    end

    assign gnt3 = gnt_q[3];
    assign gnt2 = gnt_q[2];
    assign gnt1 = gnt_q[1];
    assign gnt0 = gnt_q[0];

endmodule

// File: tb/tb_judge.sv
// tb_judge: directed checks for the judge round-robin arbiter.
// Lock-mode expectations apply when JUDGE_LOCK_EN is defined.
module tb_judge;

    logic clk;
    logic rst;
    logic req3, req2, req1, req0;
    logic gnt3, gnt2, gnt1, gnt0;
    logic [3:0] gnt;

    int errors;
    int checks;

    judge #(.RESET_LAST(3)) dut (
        .clk (clk),
        .rst (rst),
        .req3(req3),
        .req2(req2),
        .req1(req1),
        .req0(req0),
        .gnt3(gnt3),
        .gnt2(gnt2),
        .gnt1(gnt1),
        .gnt0(gnt0)
    );

    assign gnt = {gnt3, gnt2, gnt1, gnt0};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [3:0] r);
        {req3, req2, req1, req0} = r;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        set_req(4'b1111);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (gnt !== 4'b0000) begin
                errors++;
                $display("FAIL reset_hold cyc%0d got=%b exp=0000", i, gnt);
            end
        end
        rst = 1'b1;
        set_req(4'b0001);
        tick();
        checks++;
        if (gnt !== 4'b0001) begin
            errors++;
            $display("FAIL reset_release got=%b exp=0001", gnt);
        end
        set_req(4'b0000);
        tick();
    endtask

    task automatic test_single_pulse();
        set_req(4'b0000);
        tick();
        checks++;
        if (gnt !== 4'b0000) begin
            errors++;
            $display("FAIL pulse_idle got=%b exp=0000", gnt);
        end
        set_req(4'b0001);
        tick();
        set_req(4'b0000);
        checks++;
        if (gnt !== 4'b0001) begin
            errors++;
            $display("FAIL pulse_grant got=%b exp=0001", gnt);
        end
        tick();
        checks++;
        if (gnt !== 4'b0000) begin
            errors++;
            $display("FAIL pulse_drop got=%b exp=0000", gnt);
        end
    endtask

    task automatic test_rotation();
        logic [3:0] rq [5];
        logic [3:0] ex [5];
        rq = '{4'b0011, 4'b0101, 4'b1001, 4'b0001, 4'b0000};
        ex = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0000};
        for (int i = 0; i < 5; i++) begin
            set_req(rq[i]);
            tick();
            checks++;
            if (gnt !== ex[i]) begin
                errors++;
                $display("FAIL rotation cyc%0d got=%b exp=%b",
                         i + 1, gnt, ex[i]);
            end
        end
    endtask

    task automatic test_full_contention();
        logic [3:0] exp;
        rst = 1'b0;
        set_req(4'b1111);
        tick();
        rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
`ifdef JUDGE_LOCK_EN
            exp = 4'b0001;
`else
            exp = 4'b0001 << (i % 4);
`endif
            checks++;
            if (gnt !== exp) begin
                errors++;
                $display("FAIL contention cyc%0d got=%b exp=%b", i, gnt, exp);
            end
            checks++;
            if ($countones(gnt) > 1) begin
                errors++;
                $display("FAIL onehot cyc%0d got=%b exp=onehot", i, gnt);
            end
        end
        set_req(4'b0000);
        tick();
    endtask

    task automatic test_async_reset();
        logic [3:0] exp;
        rst = 1'b0;
        set_req(4'b0000);
        tick();
        rst = 1'b1;
        set_req(4'b0100);
        tick();
        checks++;
        if (gnt !== 4'b0100) begin
            errors++;
            $display("FAIL async_pre got=%b exp=0100", gnt);
        end
        set_req(4'b1100);
        #3;
        rst = 1'b0;
        #1;
        checks++;
        if (gnt !== 4'b0000) begin
            errors++;
            $display("FAIL async_clear got=%b exp=0000", gnt);
        end
        tick();
        checks++;
        if (gnt !== 4'b0000) begin
            errors++;
            $display("FAIL async_held got=%b exp=0000", gnt);
        end
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
`ifdef JUDGE_LOCK_EN
            exp = 4'b0100;
`else
            exp = (i % 2 == 0) ? 4'b0100 : 4'b1000;
`endif
            checks++;
            if (gnt !== exp) begin
                errors++;
                $display("FAIL async_restart cyc%0d got=%b exp=%b",
                         i, gnt, exp);
            end
        end
        set_req(4'b0000);
        tick();
    endtask

    task automatic test_lock();
        logic [3:0] exp;
        rst = 1'b0;
        set_req(4'b0000);
        tick();
        rst = 1'b1;
        set_req(4'b0001);
        tick();
        checks++;
        if (gnt !== 4'b0001) begin
            errors++;
            $display("FAIL lock_first got=%b exp=0001", gnt);
        end
        set_req(4'b0011);
        tick();
`ifdef JUDGE_LOCK_EN
        exp = 4'b0001;
`else
        exp = 4'b0010;
`endif
        checks++;
        if (gnt !== exp) begin
            errors++;
            $display("FAIL lock_contend got=%b exp=%b", gnt, exp);
        end
        set_req(4'b0010);
        tick();
        checks++;
        if (gnt !== 4'b0010) begin
            errors++;
            $display("FAIL lock_handover got=%b exp=0010", gnt);
        end
        set_req(4'b0000);
        tick();
    endtask

    task automatic test_back_to_back();
        set_req(4'b1000);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (gnt !== 4'b1000) begin
                errors++;
                $display("FAIL sole_hold cyc%0d got=%b exp=1000", i, gnt);
            end
        end
        set_req(4'b0100);
        tick();
        checks++;
        if (gnt !== 4'b0100) begin
            errors++;
            $display("FAIL handover got=%b exp=0100", gnt);
        end
        set_req(4'b0000);
        tick();
        checks++;
        if (gnt !== 4'b0000) begin
            errors++;
            $display("FAIL final_idle got=%b exp=0000", gnt);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst    = 1'b0;
        set_req(4'b0000);
        test_reset();
        test_single_pulse();
        test_rotation();
        test_full_contention();
        test_async_reset();
        test_lock();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
